// File: rtl/hex_pkg.sv
// ----------------------------------------------------------------------------
// hex_pkg
//   Shared types and constants for the Intel-HEX record sequencer.
//   - st_e       : record-parser FSM states
//   - ASC_*      : ASCII characters of interest on the char stream
//   - REC_*      : Intel-HEX record-type codes
//   - lrc_stb_t  : bundle of one-cycle strobes toward the LRC checker
// ----------------------------------------------------------------------------
package hex_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHK_H = 3'd3,
      ST_CHK_L = 3'd4,
      ST_CMP   = 3'd5,
      ST_RES   = 3'd6,
      ST_ABORT = 3'd7
   } st_e;

   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   localparam logic [7:0] REC_DATA  = 8'h00;
   localparam logic [7:0] REC_EOF   = 8'h01;

   // den[1]: latch high data nibble, den[0]: accumulate {DH,D}
   // lrcle[1]/[0]: load checksum high/low nibble
   // cmp: compare and clear the accumulator
   typedef struct packed {
      logic [1:0] den;
      logic [1:0] lrcle;
      logic       cmp;
   } lrc_stb_t;

endpackage

// File: rtl/hex_asc_dec.sv
// ----------------------------------------------------------------------------
// hex_asc_dec
//   Combinational ASCII classifier for the record parser.
//   Ports:
//     CH       in  8  ASCII character
//     NIB      out 4  nibble value when CH is a hex digit (don't care otherwise)
//     IS_HEX   out 1  CH is '0'-'9', 'A'-'F', or 'a'-'f' when ALLOW_LC
//     IS_COLON out 1  CH is the record start mark ':'
// ----------------------------------------------------------------------------
module hex_asc_dec
   import hex_pkg::*;
#(
   parameter bit ALLOW_LC = 1'b1
) (
   input  logic [7:0] CH,
   output logic [3:0] NIB,
   output logic       IS_HEX,
   output logic       IS_COLON
);

   logic is_dig;
   logic is_uc;
   logic is_lc;

   always_comb begin
      is_dig   = (CH >= 8'h30) && (CH <= 8'h39);
      is_uc    = (CH >= 8'h41) && (CH <= 8'h46);
      is_lc    = ALLOW_LC && (CH >= 8'h61) && (CH <= 8'h66);
      // Letters 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
      NIB      = is_dig ? CH[3:0] : (CH[3:0] + 4'd9);
      IS_HEX   = is_dig | is_uc | is_lc;
      IS_COLON = (CH == ASC_COLON);
   end

endmodule

// File: rtl/lrc_rec_seq.sv
// ----------------------------------------------------------------------------
// lrc_rec_seq
//   Intel-HEX record sequencer. Parses ':' LL AAAA TT DD..DD CC from an ASCII
//   char stream, steers every nibble into the external LRC checker and
//   reports header fields, data bytes and a per-record verdict.
//   Ports:
//     CLK, CLR                clock / async active-high reset (also clears LRC)
//     CH, CH_VLD, CH_RDY      char stream handshake
//     LRC_D, LRC_DEN,
//     LRC_LRCLE, LRC_CMP      registered strobes toward the LRC
//     LRC_ERR                 LRC verdict, valid the cycle after LRC_CMP
//     REC_LEN/ADDR/TYPE       header fields of the current record
//     DOUT, DOUT_VLD          decoded data bytes
//     REC_DONE, REC_OK,
//     BAD_CHAR, LEN_ERR       end-of-record pulse and its qualifiers
//     EOF_SEEN                sticky: a good type-01 record has completed
// ----------------------------------------------------------------------------
module lrc_rec_seq
   import hex_pkg::*;
#(
   parameter int MAX_LEN  = 255,
   parameter bit ALLOW_LC = 1'b1
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [7:0]  CH,
   input  logic        CH_VLD,
   output logic        CH_RDY,
   output logic [3:0]  LRC_D,
   output logic [1:0]  LRC_DEN,
   output logic [1:0]  LRC_LRCLE,
   output logic        LRC_CMP,
   input  logic        LRC_ERR,
   output logic [7:0]  REC_LEN,
   output logic [15:0] REC_ADDR,
   output logic [7:0]  REC_TYPE,
   output logic [7:0]  DOUT,
   output logic        DOUT_VLD,
   output logic        REC_DONE,
   output logic        REC_OK,
   output logic        BAD_CHAR,
   output logic        LEN_ERR,
   output logic        EOF_SEEN
);

   localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

   // ---------------------------------------------------------------- decode
   logic [3:0] nib;
   logic       is_hex;
   logic       is_colon;

   hex_asc_dec #(.ALLOW_LC(ALLOW_LC)) u_dec (
      .CH       (CH),
      .NIB      (nib),
      .IS_HEX   (is_hex),
      .IS_COLON (is_colon)
   );

   // ---------------------------------------------------------------- state
   st_e        state_q, state_d;
   logic [2:0] idx_q, idx_d;            // header nibble index
   logic [7:0] cnt_q, cnt_d;            // data bytes still to come
   logic       ph_q, ph_d;              // DATA: 1 = low nibble expected
   logic       res_wait_q, res_wait_d;  // RES: 1 = LRC_ERR now valid
   logic       ab_colon_q, ab_colon_d;  // abort was caused by ':' -> resync
   logic       ab_bad_q, ab_bad_d;
   logic       ab_len_q, ab_len_d;

   logic [3:0]  hi_q, hi_d;
   lrc_stb_t    stb_q, stb_d;
   logic [3:0]  lrc_d_q, lrc_d_d;
   logic [7:0]  rec_len_q, rec_len_d;
   logic [15:0] rec_addr_q, rec_addr_d;
   logic [7:0]  rec_type_q, rec_type_d;
   logic [7:0]  dout_q, dout_d;
   logic        dout_vld_q, dout_vld_d;
   logic        rec_done_q, rec_done_d;
   logic        rec_ok_q, rec_ok_d;
   logic        bad_char_q, bad_char_d;
   logic        len_err_q, len_err_d;
   logic        eof_q, eof_d;

   logic in_rec;
   logic acc;
   logic acc_hex;
   logic bad_abort;

   always_comb begin
      in_rec    = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                  (state_q == ST_CHK_H) || (state_q == ST_CHK_L);
      // CLR term keeps ready low while the async reset is held.
      CH_RDY    = ~CLR & ((state_q == ST_IDLE) | in_rec);
      acc       = CH_VLD & CH_RDY;
      acc_hex   = acc & in_rec & is_hex;
      bad_abort = acc & in_rec & ~is_hex;
   end

   // ------------------------------------------------------ state register
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ------------------------------------------------------ next state
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      ph_d       = ph_q;
      res_wait_d = res_wait_q;
      ab_colon_d = ab_colon_q;
      ab_bad_d   = ab_bad_q;
      ab_len_d   = ab_len_q;

      unique case (state_q)
         ST_IDLE: begin
            if (acc && is_colon) begin
               state_d = ST_HDR;
               idx_d   = 3'd0;
            end
         end
         ST_HDR: begin
            if (acc_hex) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  // LL is complete in rec_len_q since idx 1.
                  if ({1'b0, rec_len_q} > MAX_LEN_L) begin
                     state_d    = ST_ABORT;
                     ab_len_d   = 1'b1;
                     ab_bad_d   = 1'b0;
                     ab_colon_d = 1'b0;
                  end else if (rec_len_q == 8'd0) begin
                     state_d = ST_CHK_H;
                  end else begin
                     state_d = ST_DATA;
                     cnt_d   = rec_len_q;
                     ph_d    = 1'b0;
                  end
               end
            end
         end
         ST_DATA: begin
            if (acc_hex) begin
               ph_d = ~ph_q;
               if (ph_q) begin
                  cnt_d = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) state_d = ST_CHK_H;
               end
            end
         end
         ST_CHK_H: if (acc_hex) state_d = ST_CHK_L;
         ST_CHK_L: if (acc_hex) state_d = ST_CMP;
         ST_CMP: begin
            state_d    = ST_RES;
            res_wait_d = 1'b0;
         end
         ST_RES: begin
            // First RES cycle carries LRC_CMP; the verdict is read on the second.
            res_wait_d = ~res_wait_q;
            if (res_wait_q) state_d = ST_IDLE;
         end
         ST_ABORT: begin
            if (ab_colon_q) begin
               state_d = ST_HDR;
               idx_d   = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bad_abort) begin
         state_d    = ST_ABORT;
         ab_bad_d   = 1'b1;
         ab_len_d   = 1'b0;
         ab_colon_d = is_colon;
      end
   end

   // ------------------------------------------------------ outputs
   always_comb begin
      stb_d      = '0;
      lrc_d_d    = acc_hex ? nib : lrc_d_q;
      hi_d       = hi_q;
      rec_len_d  = rec_len_q;
      rec_addr_d = rec_addr_q;
      rec_type_d = rec_type_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      rec_done_d = 1'b0;
      rec_ok_d   = 1'b0;
      bad_char_d = 1'b0;
      len_err_d  = 1'b0;
      eof_d      = eof_q;

      unique case (state_q)
         ST_HDR: begin
            if (acc_hex) begin
               if (idx_q[0]) stb_d.den[0] = 1'b1;
               else          stb_d.den[1] = 1'b1;
               unique case (idx_q)
                  3'd0:    rec_len_d[7:4]    = nib;
                  3'd1:    rec_len_d[3:0]    = nib;
                  3'd2:    rec_addr_d[15:12] = nib;
                  3'd3:    rec_addr_d[11:8]  = nib;
                  3'd4:    rec_addr_d[7:4]   = nib;
                  3'd5:    rec_addr_d[3:0]   = nib;
                  3'd6:    rec_type_d[7:4]   = nib;
                  default: rec_type_d[3:0]   = nib;
               endcase
            end
         end
         ST_DATA: begin
            if (acc_hex) begin
               if (!ph_q) begin
                  stb_d.den[1] = 1'b1;
                  hi_d         = nib;
               end else begin
                  stb_d.den[0] = 1'b1;
                  dout_d       = {hi_q, nib};
                  dout_vld_d   = 1'b1;
               end
            end
         end
         ST_CHK_H: if (acc_hex) stb_d.lrcle[1] = 1'b1;
         ST_CHK_L: if (acc_hex) stb_d.lrcle[0] = 1'b1;
         ST_CMP:   stb_d.cmp = 1'b1;
         ST_RES: begin
            if (res_wait_q) begin
               rec_done_d = 1'b1;
               rec_ok_d   = ~LRC_ERR;
               if (~LRC_ERR && (rec_type_q == REC_EOF)) eof_d = 1'b1;
            end
         end
         ST_ABORT: begin
            // Clear the partial sum so the next record starts from zero.
            stb_d.cmp  = 1'b1;
            rec_done_d = 1'b1;
            bad_char_d = ab_bad_q;
            len_err_d  = ab_len_q;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------ datapath regs
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         idx_q      <= '0;
         cnt_q      <= '0;
         ph_q       <= 1'b0;
         res_wait_q <= 1'b0;
         ab_colon_q <= 1'b0;
         ab_bad_q   <= 1'b0;
         ab_len_q   <= 1'b0;
         hi_q       <= '0;
         stb_q      <= '0;
         lrc_d_q    <= '0;
         rec_len_q  <= '0;
         rec_addr_q <= '0;
         rec_type_q <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         rec_done_q <= 1'b0;
         rec_ok_q   <= 1'b0;
         bad_char_q <= 1'b0;
         len_err_q  <= 1'b0;
         eof_q      <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         res_wait_q <= res_wait_d;
         ab_colon_q <= ab_colon_d;
         ab_bad_q   <= ab_bad_d;
         ab_len_q   <= ab_len_d;
         hi_q       <= hi_d;
         stb_q      <= stb_d;
         lrc_d_q    <= lrc_d_d;
         rec_len_q  <= rec_len_d;
         rec_addr_q <= rec_addr_d;
         rec_type_q <= rec_type_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         rec_done_q <= rec_done_d;
         rec_ok_q   <= rec_ok_d;
         bad_char_q <= bad_char_d;
         len_err_q  <= len_err_d;
         eof_q      <= eof_d;
      end
   end

   always_comb begin
      LRC_D     = lrc_d_q;
      LRC_DEN   = stb_q.den;
      LRC_LRCLE = stb_q.lrcle;
      LRC_CMP   = stb_q.cmp;
      REC_LEN   = rec_len_q;
      REC_ADDR  = rec_addr_q;
      REC_TYPE  = rec_type_q;
      DOUT      = dout_q;
      DOUT_VLD  = dout_vld_q;
      REC_DONE  = rec_done_q;
      REC_OK    = rec_ok_q;
      BAD_CHAR  = bad_char_q;
      LEN_ERR   = len_err_q;
      EOF_SEEN  = eof_q;
   end

endmodule

// File: tb/tb_lrc_rec_seq.sv
// ----------------------------------------------------------------------------
// tb_lrc_rec_seq
//   Drives lrc_rec_seq together with a behavioural LRC checker. Directed
//   records plus randomly built records; expected outcomes come from the
//   record contents (byte sum, length limit, bad-char position).
// ----------------------------------------------------------------------------
module tb_lrc_rec_seq;

   localparam int MAXL = 16;

   logic        CLK = 1'b0;
   logic        CLR;
   logic [7:0]  CH;
   logic        CH_VLD;
   logic        CH_RDY;
   logic [3:0]  LRC_D;
   logic [1:0]  LRC_DEN;
   logic [1:0]  LRC_LRCLE;
   logic        LRC_CMP;
   logic        LRC_ERR;
   logic [7:0]  REC_LEN;
   logic [15:0] REC_ADDR;
   logic [7:0]  REC_TYPE;
   logic [7:0]  DOUT;
   logic        DOUT_VLD;
   logic        REC_DONE;
   logic        REC_OK;
   logic        BAD_CHAR;
   logic        LEN_ERR;
   logic        EOF_SEEN;

   always #5 CLK = ~CLK;

   lrc_rec_seq #(.MAX_LEN(MAXL), .ALLOW_LC(1'b1)) dut (
      .CLK(CLK), .CLR(CLR), .CH(CH), .CH_VLD(CH_VLD), .CH_RDY(CH_RDY),
      .LRC_D(LRC_D), .LRC_DEN(LRC_DEN), .LRC_LRCLE(LRC_LRCLE),
      .LRC_CMP(LRC_CMP), .LRC_ERR(LRC_ERR),
      .REC_LEN(REC_LEN), .REC_ADDR(REC_ADDR), .REC_TYPE(REC_TYPE),
      .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .REC_DONE(REC_DONE), .REC_OK(REC_OK),
      .BAD_CHAR(BAD_CHAR), .LEN_ERR(LEN_ERR), .EOF_SEEN(EOF_SEEN)
   );

   // ---------------------------------------------------------- LRC checker
   logic [3:0] m_dh;
   logic [7:0] m_sum;
   logic [7:0] m_cc;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         m_dh <= '0; m_sum <= '0; m_cc <= '0; LRC_ERR <= 1'b0;
      end else begin
         if (LRC_DEN[1])   m_dh <= LRC_D;
         if (LRC_DEN[0])   m_sum <= m_sum + {m_dh, LRC_D};
         if (LRC_LRCLE[1]) m_cc[7:4] <= LRC_D;
         if (LRC_LRCLE[0]) m_cc[3:0] <= LRC_D;
         if (LRC_CMP) begin
            LRC_ERR <= ((m_sum + m_cc) != 8'd0);
            m_sum   <= '0;
         end
      end
   end

   // ---------------------------------------------------------- checking
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------------------------------------------------- monitor
   typedef struct {
      bit          ok, bad, le;
      logic [7:0]  ll, tt;
      logic [15:0] aa;
      int          nd;
   } done_t;

   done_t      doneq[$];
   logic [7:0] dq[$];
   int         dcnt = 0;

   always @(negedge CLK) begin
      done_t r;
      if (DOUT_VLD) begin
         dq.push_back(DOUT);
         dcnt++;
      end
      if (REC_DONE) begin
         r.ok = REC_OK; r.bad = BAD_CHAR; r.le = LEN_ERR;
         r.ll = REC_LEN; r.aa = REC_ADDR; r.tt = REC_TYPE;
         r.nd = dcnt;
         dcnt = 0;
         doneq.push_back(r);
      end
   end

   // ---------------------------------------------------------- stimulus
   bit gaps = 1'b0;

   task automatic send_ch(input logic [7:0] c);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
      @(negedge CLK);
      CH = c; CH_VLD = 1'b1; n = 0;
      while (!CH_RDY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!CH_RDY) begin
         chk("rdy_timeout", 0, 1);
         CH_VLD = 1'b0;
         return;
      end
      @(posedge CLK);
      #1;
      CH_VLD = 1'b0;
      CH = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_ch(s[i]);
   endtask

   // ---------------------------------------------------------- reference
   logic [7:0]  exp_d[$];
   bit          e_ok, e_bad, e_le, e_hdr;
   logic [7:0]  e_ll, e_tt;
   logic [15:0] e_aa;
   bit          exp_eof = 1'b0;

   task automatic set_exp(input bit ok, input bit bad, input bit le, input bit hdr,
                          input logic [7:0] ll, input logic [15:0] aa, input logic [7:0] tt);
      e_ok = ok; e_bad = bad; e_le = le; e_hdr = hdr;
      e_ll = ll; e_aa = aa; e_tt = tt;
   endtask

   // Builds a record text and the outcome the record rules predict for it.
   task automatic build_rec(input int ll, input logic [15:0] aa, input logic [7:0] tt,
                            input bit corrupt, input int badpos, input bit lc,
                            output string s);
      logic [7:0] by[$];
      logic [7:0] dat[$];
      logic [7:0] sum;
      logic [7:0] cc;
      logic [7:0] bc;
      string      hx;
      by  = '{8'(ll), aa[15:8], aa[7:0], tt};
      for (int k = 0; k < ll; k++) begin
         dat.push_back(8'($urandom));
         by.push_back(dat[k]);
      end
      sum = 8'd0;
      foreach (by[i]) sum = sum + by[i];
      cc = 8'd0 - sum;
      if (corrupt) cc = cc + 8'($urandom_range(1, 255));
      by.push_back(cc);
      hx = "";
      foreach (by[i]) hx = {hx, lc ? $sformatf("%02x", by[i]) : $sformatf("%02X", by[i])};
      if (badpos >= 0) begin
         case ($urandom_range(0, 3))
            0: bc = 8'h47;  // 'G'
            1: bc = 8'h7A;  // 'z'
            2: bc = 8'h20;  // ' '
            default: bc = 8'h23;  // '#'
         endcase
         hx.putc(badpos, bc);
      end
      s = {":", hx};
      exp_d.delete();
      if (badpos >= 0 && badpos <= 7) begin
         set_exp(0, 1, 0, 0, 8'(ll), aa, tt);
      end else if (ll > MAXL) begin
         set_exp(0, 0, 1, 1, 8'(ll), aa, tt);
      end else if (badpos >= 0) begin
         set_exp(0, 1, 0, 1, 8'(ll), aa, tt);
         for (int k = 0; k < ll; k++) if (9 + 2 * k < badpos) exp_d.push_back(dat[k]);
      end else begin
         set_exp(!corrupt, 0, 0, 1, 8'(ll), aa, tt);
         foreach (dat[k]) exp_d.push_back(dat[k]);
      end
   endtask

   task automatic expect_rec(input string tag);
      int         n;
      done_t      r;
      logic [7:0] b;
      n = 0;
      while (doneq.size() == 0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      if (doneq.size() == 0) begin
         chk({tag, "_done_timeout"}, 0, 1);
         return;
      end
      r = doneq.pop_front();
      chk({tag, "_ok"},      32'(r.ok),  32'(e_ok));
      chk({tag, "_badchar"}, 32'(r.bad), 32'(e_bad));
      chk({tag, "_lenerr"},  32'(r.le),  32'(e_le));
      chk({tag, "_ndout"},   r.nd,       exp_d.size());
      for (int i = 0; i < r.nd; i++) begin
         b = (dq.size() > 0) ? dq.pop_front() : 8'hxx;
         chk({tag, "_dout"}, b, (i < exp_d.size()) ? exp_d[i] : 8'hxx);
      end
      if (e_hdr) begin
         chk({tag, "_len"},  r.ll, e_ll);
         chk({tag, "_addr"}, r.aa, e_aa);
         chk({tag, "_type"}, r.tt, e_tt);
      end
      if (e_ok && e_tt == 8'h01) exp_eof = 1'b1;
      chk({tag, "_eof"}, EOF_SEEN, exp_eof);
   endtask

   task automatic exp_case1();
      exp_d = '{8'h02, 8'h33, 8'h7A};
      set_exp(1, 0, 0, 1, 8'h03, 16'h0030, 8'h00);
   endtask

   // ---------------------------------------------------------- main
   initial begin
      string s;
      int    ll, bp;
      CLR = 1'b1; CH = 8'h00; CH_VLD = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_rdy",    CH_RDY, 0);
      chk("rst_done",   REC_DONE, 0);
      chk("rst_eof",    EOF_SEEN, 0);
      chk("rst_den",    LRC_DEN, 0);
      chk("rst_addr",   REC_ADDR, 0);
      chk("rst_dvld",   DOUT_VLD, 0);
      CLR = 1'b0;
      @(negedge CLK);
      chk("rdy_after_rst", CH_RDY, 1);

      // good record
      send_str(":0300300002337A1E"); exp_case1(); expect_rec("c1");
      // bad checksum, then good again
      send_str(":0300300002337A1F");
      exp_d = '{8'h02, 8'h33, 8'h7A};
      set_exp(0, 0, 0, 1, 8'h03, 16'h0030, 8'h00); expect_rec("c2");
      send_str(":0300300002337A1E"); exp_case1(); expect_rec("c2b");
      // EOF record, then a bad record keeps EOF_SEEN
      send_str(":00000001FF"); exp_d.delete();
      set_exp(1, 0, 0, 1, 8'h00, 16'h0000, 8'h01); expect_rec("c3");
      // bad char mid-header
      send_str(":03003G"); exp_d.delete();
      set_exp(0, 1, 0, 0, 8'h00, 16'h0000, 8'h00); expect_rec("c4");
      send_str(":0300300002337A1E"); exp_case1(); expect_rec("c4b");
      // ':' mid-header resyncs onto the new record
      send_str(":0300:0300300002337A1E"); exp_d.delete();
      set_exp(0, 1, 0, 0, 8'h00, 16'h0000, 8'h00); expect_rec("c5");
      exp_case1(); expect_rec("c5b");
      // LL above the limit
      send_str(":1100300002337A1E"); exp_d.delete();
      set_exp(0, 0, 1, 1, 8'h11, 16'h0030, 8'h00); expect_rec("lenerr");
      send_str(":0300300002337a1e"); exp_case1(); expect_rec("lc");

      // randomized records with gaps and line breaks
      gaps = 1'b1;
      for (int r = 0; r < 30; r++) begin
         ll = $urandom_range(0, MAXL + 3);
         bp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2 * ll + 9)) : -1;
         build_rec(ll, 16'($urandom), ($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00,
                   ($urandom_range(0, 5) == 0), bp, $urandom_range(0, 1) == 1, s);
         if ($urandom_range(0, 1) == 1) s = {"\r\n", s};
         send_str(s);
         expect_rec($sformatf("rnd%0d", r));
      end

      // CLR in the middle of DATA
      gaps = 1'b0;
      send_str(":04001000112233");
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      exp_eof = 1'b0;
      chk("clr_rdy",  CH_RDY, 0);
      chk("clr_len",  REC_LEN, 0);
      chk("clr_addr", REC_ADDR, 0);
      chk("clr_dout", DOUT, 0);
      chk("clr_den",  LRC_DEN, 0);
      chk("clr_eof",  EOF_SEEN, exp_eof);
      CLR = 1'b0;
      @(negedge CLK);
      chk("clr_no_done", doneq.size(), 0);
      dq.delete();
      dcnt = 0;
      send_str("\r\n:0300300002337A1E"); exp_case1(); expect_rec("after_clr");

      repeat (5) @(negedge CLK);
      chk("no_extra_done", doneq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
